// File: rtl/core_pkg.sv
// core_pkg: shared RV32I decode constants and types.
// Opcodes, ALU op encoding, immediate formats, control bundle.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_PASSB
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic jump;
   } ctrl_t;

   // alt selects SUB / SRA on the shared funct3 slots
   function automatic alu_op_e alu_op_from_f3(
      input logic [2:0] f3,
      input logic       alt
   );
      alu_op_e op;
      unique case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: RV32I immediate format select and sign extension.
// Purely combinational; shared with the fetch branch predictor.
module imm_gen import core_pkg::*; (
   input  logic [31:0]     i_instr,
   input  imm_fmt_e        i_fmt,
   output logic [XLEN-1:0] o_imm
);

   // pick the format and sign-extend from instr[31]
   always_comb begin
      o_imm = '0;
      unique case (i_fmt)
         IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25],
                         i_instr[11:7]};
         IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31],
                         i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
         IMM_U: o_imm = {i_instr[31:12], 12'b0};
         IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31],
                         i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with load-use bubble and ID/EX register.
// Optional DECODE_PERF_CNT_EN adds a saturating bubble counter port.
module decode_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  if_valid_i,
   input  logic [31:0]           if_instr_i,
   input  logic [XLEN-1:0]       if_pc_i,
   output logic                  id_ready_o,
   output logic [REG_ADDR_W-1:0] rs1_label_o,
   output logic [REG_ADDR_W-1:0] rs2_label_o,
   input  logic [XLEN-1:0]       rs1_data_i,
   input  logic [XLEN-1:0]       rs2_data_i,
   input  logic                  flush_i,
   input  logic                  ex_ready_i,
   output logic                  ex_valid_o,
   output logic [XLEN-1:0]       ex_pc_o,
   output logic [XLEN-1:0]       ex_rs1_data_o,
   output logic [XLEN-1:0]       ex_rs2_data_o,
   output logic [XLEN-1:0]       ex_imm_o,
   output logic [REG_ADDR_W-1:0] ex_rd_label_o,
   output logic [REG_ADDR_W-1:0] ex_rs1_label_o,
   output logic [REG_ADDR_W-1:0] ex_rs2_label_o,
   output logic [3:0]            ex_alu_op_o,
   output logic                  ex_alu_src_o,
   output logic                  ex_reg_write_o,
   output logic                  ex_mem_read_o,
   output logic                  ex_mem_write_o,
   output logic                  ex_branch_o,
   output logic                  ex_jump_o,
   output logic [2:0]            ex_funct3_o
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [15:0]           bubble_cnt_o
`endif
);

   import core_pkg::*;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_BUBBLE = 1'b1;

   logic [6:0]            w_opc;
   logic [2:0]            w_f3;
   logic [4:0]            w_rd_raw;
   logic                  w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
   logic                  w_is_br, w_is_ld, w_is_st, w_is_opi, w_is_op;
   logic                  w_known;
   logic                  w_uses_rs1, w_uses_rs2, w_writes;
   imm_fmt_e              w_fmt;
   alu_op_e               w_alu_op;
   logic                  w_alu_src;
   ctrl_t                 w_ctrl;
   logic [XLEN-1:0]       w_imm;
   logic [REG_ADDR_W-1:0] w_rs1_lbl, w_rs2_lbl, w_rd_lbl;
   logic                  w_advance, w_hazard;

   logic [0:0]            r_state;
   logic                  r_valid;
   ctrl_t                 r_ctrl;
   logic [XLEN-1:0]       r_pc, r_rs1_data, r_rs2_data, r_imm;
   logic [REG_ADDR_W-1:0] r_rd, r_rs1, r_rs2;
   alu_op_e               r_alu_op;
   logic                  r_alu_src;
   logic [2:0]            r_f3;

   assign w_opc    = if_instr_i[6:0];
   assign w_f3     = if_instr_i[14:12];
   assign w_rd_raw = if_instr_i[11:7];

   assign w_is_lui   = (w_opc == OPC_LUI);
   assign w_is_auipc = (w_opc == OPC_AUIPC);
   assign w_is_jal   = (w_opc == OPC_JAL);
   assign w_is_jalr  = (w_opc == OPC_JALR);
   assign w_is_br    = (w_opc == OPC_BRANCH);
   assign w_is_ld    = (w_opc == OPC_LOAD);
   assign w_is_st    = (w_opc == OPC_STORE);
   assign w_is_opi   = (w_opc == OPC_OP_IMM);
   assign w_is_op    = (w_opc == OPC_OP);

   // opcode decode into sources, format, ALU select and control bits
   always_comb begin
      w_known    = 1'b1;
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      w_writes   = 1'b0;
      w_fmt      = IMM_NONE;
      w_alu_op   = ALU_ADD;
      w_alu_src  = 1'b0;
      w_ctrl     = '0;
      unique case (1'b1)
         w_is_lui: begin
            w_fmt = IMM_U; w_writes = 1'b1;
            w_alu_op = ALU_PASSB; w_alu_src = 1'b1;
         end
         w_is_auipc: begin
            w_fmt = IMM_U; w_writes = 1'b1;
            w_alu_src = 1'b1;
         end
         w_is_jal: begin
            w_fmt = IMM_J; w_writes = 1'b1;
            w_alu_src = 1'b1; w_ctrl.jump = 1'b1;
         end
         w_is_jalr: begin
            w_fmt = IMM_I; w_writes = 1'b1; w_uses_rs1 = 1'b1;
            w_alu_src = 1'b1; w_ctrl.jump = 1'b1;
         end
         w_is_br: begin
            w_fmt = IMM_B; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            w_alu_op = ALU_SUB; w_ctrl.branch = 1'b1;
         end
         w_is_ld: begin
            w_fmt = IMM_I; w_writes = 1'b1; w_uses_rs1 = 1'b1;
            w_alu_src = 1'b1; w_ctrl.mem_read = 1'b1;
         end
         w_is_st: begin
            w_fmt = IMM_S; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            w_alu_src = 1'b1; w_ctrl.mem_write = 1'b1;
         end
         w_is_opi: begin
            w_fmt = IMM_I; w_writes = 1'b1; w_uses_rs1 = 1'b1;
            w_alu_src = 1'b1;
            w_alu_op = alu_op_from_f3(w_f3,
               if_instr_i[30] & (w_f3 == 3'b101));
         end
         w_is_op: begin
            w_writes = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            w_alu_op = alu_op_from_f3(w_f3, if_instr_i[30]);
         end
         default: w_known = 1'b0;
      endcase
      w_ctrl.reg_write = w_writes && (w_rd_raw != 5'd0);
   end

   assign w_rs1_lbl = w_uses_rs1 ?
      REG_ADDR_W'(if_instr_i[19:15]) : '0;
   assign w_rs2_lbl = w_uses_rs2 ?
      REG_ADDR_W'(if_instr_i[24:20]) : '0;
   assign w_rd_lbl  = w_writes ? REG_ADDR_W'(w_rd_raw) : '0;

   assign rs1_label_o = w_rs1_lbl;
   assign rs2_label_o = w_rs2_lbl;

   imm_gen u_imm_gen (
      .i_instr (if_instr_i),
      .i_fmt   (w_fmt),
      .o_imm   (w_imm)
   );

   assign w_advance = !r_valid || ex_ready_i;
   assign w_hazard  = if_valid_i && r_valid && r_ctrl.mem_read &&
                      (r_rd != '0) &&
                      ((w_uses_rs1 && (w_rs1_lbl == r_rd)) ||
                       (w_uses_rs2 && (w_rs2_lbl == r_rd)));
   assign id_ready_o = w_advance && !w_hazard && !flush_i;

   // ID/EX register: flush, bubble insertion, or load the decoded word
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_RUN;
         r_valid    <= 1'b0;
         r_ctrl     <= '0;
         r_pc       <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_rd       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_alu_op   <= ALU_ADD;
         r_alu_src  <= 1'b0;
         r_f3       <= '0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_state <= ST_RUN;
      end else if (w_advance) begin
         if ((r_state == ST_RUN) && w_hazard) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_state <= ST_BUBBLE;
         end else begin
            r_valid    <= if_valid_i;
            r_ctrl     <= if_valid_i ? w_ctrl : '0;
            r_pc       <= if_pc_i;
            r_rs1_data <= rs1_data_i;
            r_rs2_data <= rs2_data_i;
            r_imm      <= w_imm;
            r_rd       <= w_rd_lbl;
            r_rs1      <= w_rs1_lbl;
            r_rs2      <= w_rs2_lbl;
            r_alu_op   <= w_alu_op;
            r_alu_src  <= w_alu_src;
            r_f3       <= w_known ? w_f3 : 3'b000;
            r_state    <= ST_RUN;
         end
      end
   end

`ifdef DECODE_PERF_CNT_EN
   logic [15:0] r_bubble_cnt;

   // count load-use bubbles, saturating; flush clears are not bubbles
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bubble_cnt <= '0;
      end else if (!flush_i && w_advance && (r_state == ST_RUN) &&
                   w_hazard && (r_bubble_cnt != 16'hFFFF)) begin
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
   end

   assign bubble_cnt_o = r_bubble_cnt;
`endif

   assign ex_valid_o     = r_valid;
   assign ex_pc_o        = r_pc;
   assign ex_rs1_data_o  = r_rs1_data;
   assign ex_rs2_data_o  = r_rs2_data;
   assign ex_imm_o       = r_imm;
   assign ex_rd_label_o  = r_rd;
   assign ex_rs1_label_o = r_rs1;
   assign ex_rs2_label_o = r_rs2;
   assign ex_alu_op_o    = r_alu_op;
   assign ex_alu_src_o   = r_alu_src;
   assign ex_reg_write_o = r_ctrl.reg_write;
   assign ex_mem_read_o  = r_ctrl.mem_read;
   assign ex_mem_write_o = r_ctrl.mem_write;
   assign ex_branch_o    = r_ctrl.branch;
   assign ex_jump_o      = r_ctrl.jump;
   assign ex_funct3_o    = r_f3;

endmodule
